// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding and default geometry for the configuration shift chain.
package cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cfg_state_t;
  localparam int CFG_WIDTH = 5;
  localparam int CFG_DEPTH = 4;
endpackage

// File: rtl/cfg_stage.sv
// cfg_stage: one logic block's active configuration word with load, sync clear and async reset.
module cfg_stage
  import cfg_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else if (i_clear) r_q <= '0;
    else if (i_load) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/cfg_shift_chain.sv
// cfg_shift_chain: serial config loader with frame checking and atomic commit.
// The active image port is cfg_config because config is a reserved word.
module cfg_shift_chain
  import cfg_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH,
  parameter int DEPTH = CFG_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_bit,
  input  logic                   cfg_last,
  output logic                   cfg_out,
  output logic [WIDTH*DEPTH-1:0] cfg_config,
  output logic                   loaded,
  output logic                   err
);
  localparam int N  = WIDTH * DEPTH;
  localparam int CW = $clog2(N + 1);
  cfg_state_t    r_state;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_shadow;
  logic          r_loaded;
  logic          r_err;
  logic          w_commit;
  logic          w_accept;
  logic          w_full;
  assign w_commit  = r_state == COMMIT;
  assign cfg_ready = !w_commit && !clear;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_full    = r_count == CW'(N - 1);
  // A frame ends on cfg_last or on the Nth bit; only both together is a good frame.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else if (clear) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_loaded <= w_commit;
      if (w_commit) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (w_accept) begin
        r_shadow <= {r_shadow[N-2:0], cfg_bit};
        r_count  <= (cfg_last || w_full) ? '0 : r_count + CW'(1);
        r_state  <= (cfg_last && w_full) ? COMMIT : (cfg_last || w_full) ? IDLE : SHIFT;
        if (cfg_last != w_full) r_err <= 1'b1;
      end
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    cfg_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk  (clk),
      .i_rst_n(reset),
      .i_clear(clear),
      .i_load (w_commit),
      .i_d    (r_shadow[i*WIDTH +: WIDTH]),
      .o_q    (cfg_config[i*WIDTH +: WIDTH])
    );
  end
  assign cfg_out = r_shadow[N-1];
  assign loaded  = r_loaded;
  assign err     = r_err;
endmodule
